// File: rtl/store_buffer.sv
// Posted-write buffer: queues word-aligned stores and drains them to memory over valid/ready.
// Optional macro STORE_BUFFER_ADDR_CHECK_EN narrows the load hazard to matching words only.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_byte_enable,

    input  logic        ld_check,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,

    output logic        empty,
    output logic [$clog2(DEPTH):0] count,
    output logic        err_be_zero
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    // Entry storage carries no reset; validity is tracked by count/pointers alone.
    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  be_q   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_be_zero_q, err_be_zero_d;

    logic st_fire;
    logic push;
    logic pop;
    logic hazard;

    always_comb begin
        st_fire = st_valid && st_ready;
        push    = st_fire && (st_byte_enable != 4'b0000);
        pop     = mem_valid && mem_ready;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        err_be_zero_d = st_fire && (st_byte_enable == 4'b0000);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_be_zero_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            err_be_zero_q <= err_be_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr[31:2];
            data_q[wr_ptr_q] <= st_data;
            be_q[wr_ptr_q]   <= st_byte_enable;
        end
    end

    // No full-bypass: readiness depends on registered count only.
    always_comb begin
        st_ready        = (count_q != Full);
        mem_valid       = (count_q != '0);
        empty           = (count_q == '0);
        count           = count_q;
        err_be_zero     = err_be_zero_q;
        mem_addr        = {addr_q[rd_ptr_q], 2'b00};
        mem_wdata       = data_q[rd_ptr_q];
        mem_byte_enable = be_q[rd_ptr_q];
    end

`ifdef STORE_BUFFER_ADDR_CHECK_EN
    logic [DEPTH-1:0] entry_live;
    logic [DEPTH-1:0] entry_match;
    logic [1:0]       unused_addr_bits;

    // An entry is live when its distance from the head is below count.
    always_comb begin
        entry_live  = '0;
        entry_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i]  = CntW'(PtrW'(i) - rd_ptr_q) < count_q;
            entry_match[i] = entry_live[i] && (addr_q[i] == ld_addr[31:2]);
        end
        hazard = |entry_match;
    end

    assign unused_addr_bits = st_addr[1:0] ^ ld_addr[1:0];
`else
    logic unused_addr_bits;

    // Conservative: any pending store blocks every load.
    always_comb begin
        hazard = (count_q != '0);
    end

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr};
`endif

    always_comb begin
        ld_stall = ld_check && hazard;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
// Expectations for the hazard case follow STORE_BUFFER_ADDR_CHECK_EN when it is defined.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_byte_enable;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        empty;
    logic [2:0]  count;
    logic        err_be_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_addr         (st_addr),
        .st_data         (st_data),
        .st_byte_enable  (st_byte_enable),
        .ld_check        (ld_check),
        .ld_addr         (ld_addr),
        .ld_stall        (ld_stall),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .empty           (empty),
        .count           (count),
        .err_be_zero     (err_be_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid       = 1'b1;
        st_addr        = a;
        st_data        = d;
        st_byte_enable = be;
        tick();
        st_valid       = 1'b0;
    endtask

    initial begin
        int n_push;
        int n_pop;
        logic exp_far_stall;

        rst            = 1'b1;
        st_valid       = 1'b0;
        st_addr        = '0;
        st_data        = '0;
        st_byte_enable = '0;
        ld_check       = 1'b0;
        ld_addr        = '0;
        mem_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        ld_check = 1'b1;
        ld_addr  = 32'h100;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_ld_stall", 32'(ld_stall), 32'd0);
        check("rst_err", 32'(err_be_zero), 32'd0);
        ld_check = 1'b0;

        // Single word store, presented the cycle after acceptance
        push(32'h100, 32'hDEADBEEF, 4'b1111);
        check("sw_mem_valid", 32'(mem_valid), 32'd1);
        check("sw_mem_addr", mem_addr, 32'h100);
        check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_mem_be", 32'(mem_byte_enable), 32'hF);
        check("sw_count", 32'(count), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sw_empty", 32'(empty), 32'd1);
        check("sw_mem_valid_off", 32'(mem_valid), 32'd0);

        // Fill to DEPTH with memory stalled
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'h1000 + 32'(i), 4'b0011);
        check("fill_count", 32'(count), 32'd4);
        check("fill_st_ready", 32'(st_ready), 32'd0);
        check("fill_head_be", 32'(mem_byte_enable), 32'h3);
        // Full: store refused even though a pop happens on the same edge
        st_valid       = 1'b1;
        st_addr        = 32'h10;
        st_data        = 32'h5555;
        st_byte_enable = 4'b1111;
        mem_ready      = 1'b1;
        tick();
        st_valid = 1'b0;
        check("full_pop_count", 32'(count), 32'd3);
        check("full_err", 32'(err_be_zero), 32'd0);
        for (int i = 1; i < 4; i++) begin
            check("drain_valid", 32'(mem_valid), 32'd1);
            check("drain_addr", mem_addr, 32'(4 * i));
            check("drain_data", mem_wdata, 32'h1000 + 32'(i));
            tick();
        end
        mem_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Wrap: 10 stores while mem_ready toggles every cycle
        n_push = 0;
        n_pop  = 0;
        for (int cyc = 0; cyc < 100 && n_pop < 10; cyc++) begin
            st_valid       = (n_push < 10);
            st_addr        = 32'h300 + 32'(4 * n_push);
            st_data        = 32'hA000 + 32'(n_push);
            st_byte_enable = 4'b1111;
            mem_ready      = (cyc % 2 == 1);
            #1;
            check("wrap_count_max", 32'(count <= 3'd4), 32'd1);
            if (mem_valid && mem_ready) begin
                check("wrap_addr", mem_addr, 32'h300 + 32'(4 * n_pop));
                check("wrap_data", mem_wdata, 32'hA000 + 32'(n_pop));
                n_pop++;
            end
            if (st_valid && st_ready) n_push++;
            tick();
        end
        st_valid  = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("wrap_pushes", 32'(n_push), 32'd10);
        check("wrap_pops", 32'(n_pop), 32'd10);
        check("wrap_empty", 32'(empty), 32'd1);

        // Zero byte enables: handshake completes, nothing queued
        check("bez_ready", 32'(st_ready), 32'd1);
        push(32'h203, 32'h77, 4'b0000);
        check("bez_err", 32'(err_be_zero), 32'd1);
        check("bez_count", 32'(count), 32'd0);
        check("bez_mem_valid", 32'(mem_valid), 32'd0);
        tick();
        check("bez_err_pulse", 32'(err_be_zero), 32'd0);

        // Load hazard
`ifdef STORE_BUFFER_ADDR_CHECK_EN
        exp_far_stall = 1'b0;
`else
        exp_far_stall = 1'b1;
`endif
        push(32'h40, 32'h1234, 4'b1111);
        ld_check = 1'b1;
        ld_addr  = 32'h42;
        #1;
        check("hz_same_word", 32'(ld_stall), 32'd1);
        ld_addr = 32'h80;
        #1;
        check("hz_other_word", 32'(ld_stall), 32'(exp_far_stall));
        ld_check = 1'b0;
        #1;
        check("hz_no_load", 32'(ld_stall), 32'd0);
        ld_check  = 1'b1;
        ld_addr   = 32'h42;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("hz_after_pop", 32'(ld_stall), 32'd0);
        ld_check = 1'b0;

        // Async reset mid-drain
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 32'(i), 4'b1111);
        check("ar_count_pre", 32'(count), 32'd3);
        check("ar_valid_pre", 32'(mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_mem_valid", 32'(mem_valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_st_ready", 32'(st_ready), 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ar_no_write", 32'(mem_valid), 32'd0);
        end
        mem_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
